// File: rtl/arith_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : arith_unit_pipe
// Description : Two-stage pipelined arithmetic unit, G = A + Y + C_in, where
//               Y = {0, B, ~B, all-ones} chosen by sel. Valid/ready handshakes
//               on both sides; carry, overflow, zero and negative flags.
//               Optional macro ARITH_SAT_EN clamps G_out to the signed limit
//               on overflow (stage 2, no added latency).
// Revision    : 1.0 - initial release
// ============================================================================
module arith_unit_pipe #(
    parameter int WIDTH      = 8,
    parameter int SEL_LENGTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic                  C_in,
    input  logic [SEL_LENGTH-1:0] sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      G_out,
    output logic                  C_out,
    output logic                  V_out,
    output logic                  Z_out,
    output logic                  N_out
);

    localparam int c_msb = WIDTH - 1;

    // Configuration sanity: the mux is defined only for a 2-bit select, and
    // the signed-overflow flag needs at least a sign bit plus one data bit.
    generate
        if (SEL_LENGTH != 2) begin : g_bad_sel_length
            $error("arith_unit_pipe: SEL_LENGTH must be 2");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("arith_unit_pipe: WIDTH must be >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake / advance control
    // ------------------------------------------------------------------
    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_a;
    logic [WIDTH-1:0]     r_s1_y;
    logic                 r_s1_cin;
    logic                 w_s2_load;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_y;

    // Stage 2 takes a beat when it is empty or its current result leaves
    // this cycle; stage 1 frees up whenever it is empty or hands over.
    assign w_s2_load = r_s1_valid && (!out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_accept  = in_valid && in_ready;

    // Y operand mux, evaluated at accept time so later sel/B changes are
    // invisible to a beat already taken.
    always_comb begin
        w_y = '0;
        case (sel)
            2'b00:   w_y = '0;
            2'b01:   w_y = B;
            2'b10:   w_y = ~B;
            2'b11:   w_y = '1;
            default: w_y = '0;
        endcase
    end

    // Stage 1 occupancy: a simultaneous accept and hand-over keeps it full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 1 operand capture; contents are only meaningful with r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_a   <= A;
            r_s1_y   <= w_y;
            r_s1_cin <= C_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 arithmetic
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_g;

    assign w_sum = {1'b0, r_s1_a} + {1'b0, r_s1_y} + {{WIDTH{1'b0}}, r_s1_cin};

    // Signed overflow: like-signed operands produced a result of the other sign.
    assign w_ovf = (r_s1_a[c_msb] == r_s1_y[c_msb]) && (w_sum[c_msb] != r_s1_a[c_msb]);

`ifdef ARITH_SAT_EN
    localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp toward the sign of A; overflow can only occur when A and Y agree.
    always_comb begin
        w_g = w_sum[WIDTH-1:0];
        if (w_ovf) begin
            w_g = r_s1_a[c_msb] ? c_smin : c_smax;
        end
    end
`else
    assign w_g = w_sum[WIDTH-1:0];
`endif

    // Output register: reloads on s2_load, otherwise holds through stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            G_out <= '0;
            C_out <= 1'b0;
            V_out <= 1'b0;
            Z_out <= 1'b0;
            N_out <= 1'b0;
        end else if (w_s2_load) begin
            G_out <= w_g;
            C_out <= w_sum[WIDTH];
            V_out <= w_ovf;
            Z_out <= (w_g == '0);
            N_out <= w_g[c_msb];
        end
    end

    // Output valid: a new load wins over a completing handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (w_s2_load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arith_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_unit_pipe
// Description : Scoreboard bench for arith_unit_pipe (WIDTH=8). Expected
//               results come from an integer/signed reference model; a
//               monitor compares the queue head whenever out_valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_unit_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         C_in = 1'b0;
    logic [1:0]   sel = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] G_out;
    logic         C_out, V_out, Z_out, N_out;

    typedef struct packed {
        logic [W-1:0] g;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   rand_ready = 1'b0;

    always #5 clk = ~clk;

    arith_unit_pipe #(.WIDTH(W), .SEL_LENGTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C_in(C_in), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .G_out(G_out), .C_out(C_out), .V_out(V_out), .Z_out(Z_out), .N_out(N_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain unsigned and signed integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic [1:0] s);
        exp_t e;
        int   y, full, sa, sy, ss, g;
        case (s)
            2'd0:    y = 0;
            2'd1:    y = int'(b);
            2'd2:    y = 255 - int'(b);
            default: y = 255;
        endcase
        full = int'(a) + y + int'(cin);
        g    = full % 256;
        sa   = (int'(a) >= 128) ? int'(a) - 256 : int'(a);
        sy   = (y >= 128) ? y - 256 : y;
        ss   = sa + sy + int'(cin);
`ifdef ARITH_SAT_EN
        if (ss > 127)  g = 127;
        if (ss < -128) g = 128;
`endif
        e.g = 8'(g);
        e.c = (full >= 256);
        e.v = (ss > 127) || (ss < -128);
        e.z = (g == 0);
        e.n = (g >= 128);
        return e;
    endfunction

    // Scoreboard push on every accepted beat.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready)
            exp_q.push_back(model(A, B, C_in, sel));
    end

    // Monitor: head must be presented (and held) while out_valid; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_e = exp_q[0];
                check("G_out", {24'd0, G_out}, {24'd0, mon_e.g});
                check("C_out", {31'd0, C_out}, {31'd0, mon_e.c});
                check("V_out", {31'd0, V_out}, {31'd0, mon_e.v});
                check("Z_out", {31'd0, Z_out}, {31'd0, mon_e.z});
                check("N_out", {31'd0, N_out}, {31'd0, mon_e.n});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Random back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [1:0] s, output int waits);
        int t;
        t        = 0;
        in_valid = 1'b1;
        A = a; B = b; C_in = cin; sel = s;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
        waits = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_G_out"}, {24'd0, G_out}, 32'd0);
        check({tag, "_flags"}, {28'd0, C_out, V_out, Z_out, N_out}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [W-1:0] corners [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    initial begin
        int w, stall_sum, run, maxrun, nvalid;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("reset");

        // Directed operation identities
        out_ready = 1'b1;
        send(8'h7F, 8'h01, 1'b0, 2'b01, w);
        send(8'h05, 8'h03, 1'b1, 2'b10, w);
        send(8'h03, 8'h05, 1'b1, 2'b10, w);
        send(8'hFF, 8'h00, 1'b1, 2'b00, w);
        send(8'h00, 8'h00, 1'b0, 2'b11, w);
        send(8'h80, 8'hFF, 1'b0, 2'b01, w);
        send(8'h5A, 8'h00, 1'b0, 2'b00, w);
        drain();

        // Back-pressure: two beats fill the pipe
        out_ready = 1'b0;
        send(8'd1, 8'h00, 1'b0, 2'b00, w);
        send(8'd2, 8'h00, 1'b0, 2'b00, w);
        in_valid = 1'b1; A = 8'd3; B = 8'h00; C_in = 1'b0; sel = 2'b00;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        fork
            begin
                send(8'd3, 8'h00, 1'b0, 2'b00, w);
                send(8'd4, 8'h00, 1'b0, 2'b00, w);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bp_release_valid", {31'd0, out_valid}, 32'd1);
                end
            end
        join
        drain();

        // Streaming: 16 back-to-back beats
        stall_sum = 0; run = 0; maxrun = 0; nvalid = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(pick(), pick(), 1'($urandom), 2'($urandom), w);
                    stall_sum += w;
                end
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (out_valid) begin
                        nvalid++;
                        run++;
                        if (run > maxrun) maxrun = run;
                    end else begin
                        run = 0;
                    end
                end
            end
        join
        check("stream_stalls", stall_sum, 32'd0);
        check("stream_valid_count", nvalid, 32'd16);
        check("stream_valid_run", maxrun, 32'd16);
        drain();

        // Randomized traffic with random back-pressure
        rand_ready = 1'b1;
        repeat (300) begin
            send(pick(), pick(), 1'($urandom), 2'($urandom), w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 2'b01, w);
        send(8'h33, 8'h44, 1'b1, 2'b01, w);
        apply_reset();
        check_reset_state("midreset");
        out_ready = 1'b1;
        nvalid = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) nvalid++;
        end
        check("midreset_no_output", nvalid, 32'd0);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
